// File: rtl/rabbit_pkg.sv
// Shared definitions for the Rabbit cipher core: sequencer states, setup length
// and the counter-system constants used by the datapath.
package rabbit_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_LOAD,
        ST_KEY_ITER,
        ST_KEY_WAIT,
        ST_KEY_FIX,
        ST_IV_LOAD,
        ST_IV_ITER,
        ST_IV_WAIT,
        ST_GEN_ITER,
        ST_GEN_WAIT,
        ST_BLK_OUT,
        ST_READY
    } state_t;

    localparam int SETUP_ITERS_DEF = 4;

    // Counter increment constants A0..A7 of the counter-update step.
    localparam logic [31:0] A0 = 32'h4D34D34D;
    localparam logic [31:0] A1 = 32'hD34D34D3;
    localparam logic [31:0] A2 = 32'h34D34D34;
    localparam logic [31:0] A3 = 32'h4D34D34D;
    localparam logic [31:0] A4 = 32'hD34D34D3;
    localparam logic [31:0] A5 = 32'h34D34D34;
    localparam logic [31:0] A6 = 32'h4D34D34D;
    localparam logic [31:0] A7 = 32'hD34D34D3;

endpackage

// File: rtl/rabbit_seq_ctrl.sv
// Rabbit sequencer: steps the datapath through key setup, IV setup and
// keystream generation, with command checking and an iteration watchdog.
//
// state    | meaning
// IDLE     | no key; only key_load accepted
// KEY_LOAD | load X/C from key, clear carry
// KEY_ITER | launch one key-setup iteration
// KEY_WAIT | wait for iter_done (watchdog armed)
// KEY_FIX  | counter fix-up, key becomes valid
// IV_LOAD  | restore master state, XOR IV into counters
// IV_ITER  | launch one IV-setup iteration
// IV_WAIT  | wait for iter_done (watchdog armed)
// GEN_ITER | launch one keystream iteration
// GEN_WAIT | wait for iter_done (watchdog armed)
// BLK_OUT  | block valid until blk_ack
// READY    | keyed and waiting for a command
module rabbit_seq_ctrl
    import rabbit_pkg::*;
#(
    parameter int SETUP_ITERS = SETUP_ITERS_DEF,
    parameter int BLK_CNT_W   = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_load,
    input  logic                 iv_load,
    input  logic                 ks_req,
    input  logic                 iter_done,
    input  logic                 blk_ack,
    output logic                 load_key_state,
    output logic                 carry_clr,
    output logic                 fix_counters,
    output logic                 load_iv,
    output logic                 iter_start,
    output logic                 blk_valid,
    output logic                 busy,
    output logic                 key_ok,
    output logic                 err,
    output logic [BLK_CNT_W-1:0] blk_count
);

    localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]      ITERS   = 3'(SETUP_ITERS);

    state_t          state;
    state_t          state_next;
    logic [2:0]      iter_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            in_wait;
    logic            key_accept;
    logic            iv_accept;
    logic            cmd_err;
    logic            timeout;
    logic            any_cmd;

    assign in_wait = (state == ST_KEY_WAIT) || (state == ST_IV_WAIT) || (state == ST_GEN_WAIT);
    assign any_cmd = key_load || iv_load || ks_req;

    always_comb begin
        state_next = state;
        key_accept = 1'b0;
        iv_accept  = 1'b0;
        timeout    = 1'b0;
        cmd_err    = any_cmd && (state != ST_IDLE) && (state != ST_READY);

        // A completion arriving on the expiry cycle wins over the watchdog.
        if (in_wait && !iter_done && (wd_cnt == '0)) begin
            timeout    = 1'b1;
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (key_load) begin
                        key_accept = 1'b1;
                        state_next = ST_KEY_LOAD;
                    end else if (iv_load || ks_req) begin
                        cmd_err = 1'b1;
                    end
                end
                ST_READY: begin
                    if (key_load) begin
                        key_accept = 1'b1;
                        state_next = ST_KEY_LOAD;
                    end else if (iv_load) begin
                        iv_accept  = 1'b1;
                        state_next = ST_IV_LOAD;
                    end else if (ks_req) begin
                        state_next = ST_GEN_ITER;
                    end
                end
                ST_KEY_LOAD: state_next = ST_KEY_ITER;
                ST_KEY_ITER: state_next = ST_KEY_WAIT;
                ST_KEY_WAIT: begin
                    if (iter_done) state_next = (iter_cnt < ITERS) ? ST_KEY_ITER : ST_KEY_FIX;
                end
                ST_KEY_FIX:  state_next = ST_READY;
                ST_IV_LOAD:  state_next = ST_IV_ITER;
                ST_IV_ITER:  state_next = ST_IV_WAIT;
                ST_IV_WAIT: begin
                    if (iter_done) state_next = (iter_cnt < ITERS) ? ST_IV_ITER : ST_READY;
                end
                ST_GEN_ITER: state_next = ST_GEN_WAIT;
                ST_GEN_WAIT: begin
                    if (iter_done) state_next = ST_BLK_OUT;
                end
                ST_BLK_OUT: begin
                    if (blk_ack) state_next = ST_READY;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            iter_cnt  <= 3'd0;
            wd_cnt    <= WD_LOAD;
            key_ok    <= 1'b0;
            err       <= 1'b0;
            blk_count <= '0;
        end else begin
            state <= state_next;

            if (key_accept || iv_accept) iter_cnt <= 3'd0;
            else if (iter_start)         iter_cnt <= iter_cnt + 3'd1;

            if (in_wait) wd_cnt <= wd_cnt - WD_W'(1);
            else         wd_cnt <= WD_LOAD;

            if (key_accept || timeout)  key_ok <= 1'b0;
            else if (state == ST_KEY_FIX) key_ok <= 1'b1;

            if (key_accept)             err <= 1'b0;
            else if (cmd_err || timeout) err <= 1'b1;

            if (key_accept || iv_accept)             blk_count <= '0;
            else if ((state == ST_BLK_OUT) && blk_ack) blk_count <= blk_count + BLK_CNT_W'(1);
        end
    end

    // Control pulses are pure decodes of the state register.
    always_comb begin
        load_key_state = (state == ST_KEY_LOAD);
        carry_clr      = (state == ST_KEY_LOAD);
        fix_counters   = (state == ST_KEY_FIX);
        load_iv        = (state == ST_IV_LOAD);
        iter_start     = (state == ST_KEY_ITER) || (state == ST_IV_ITER) || (state == ST_GEN_ITER);
        blk_valid      = (state == ST_BLK_OUT);
        busy           = (state != ST_IDLE) && (state != ST_READY);
    end

endmodule
